// File: rtl/fifo_pkg.sv
// Shared definitions for the RAM-backed FIFO controller: FSM state
// encoding and the almost-full margin used by the optional level outputs.
package fifo_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    FLUSH  = 2'd2
  } fifo_state_e;

  localparam int ALMOST_FULL_MARGIN = 4;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of an external simple dual-port block RAM
// (registered read address, 1-cycle read latency).
// The RAM read address is steered one entry ahead on pop cycles so the
// head word is always waiting on ram_r_data.
// Optional feature: define RAM_FIFO_LEVEL_EN to add the level and
// almost_full outputs.
module ram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  freeze,
  input  logic                  flush,
  output logic                  frozen,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_r_data
`ifdef RAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full
`endif
);

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(WORDS);
  localparam logic [ADDR_WIDTH:0]   ZERO_COUNT = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   ONE_COUNT  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_PTR   = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE_PTR    = (ADDR_WIDTH)'(1);

  fifo_state_e           r_state;
  logic                  r_frozen;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // Handshake decode; in_ready is held low for the whole time rst is high.
  always_comb begin
    in_ready   = (!rst) && (r_state == RUN) && (r_count != FULL_COUNT);
    out_valid  = (r_state == RUN) && (r_count != ZERO_COUNT);
    w_push     = in_valid && in_ready;
    w_pop      = out_valid && out_ready;
    out_data   = ram_r_data;
    frozen     = r_frozen;
    ram_we     = w_push;
    ram_w_addr = r_wr_ptr;
    ram_w_data = in_data;
    if (w_pop) begin
      ram_r_addr = r_rd_ptr + ONE_PTR;
    end else begin
      ram_r_addr = r_rd_ptr;
    end
  end

  // Next occupancy: push/pop adjust in RUN, FLUSH empties, FREEZE holds.
  always_comb begin
    w_count_nxt = r_count;
    case (r_state)
      RUN: begin
        case ({w_push, w_pop})
          2'b10:   w_count_nxt = r_count + ONE_COUNT;
          2'b01:   w_count_nxt = r_count - ONE_COUNT;
          default: w_count_nxt = r_count;
        endcase
      end
      FLUSH:   w_count_nxt = ZERO_COUNT;
      default: w_count_nxt = r_count;
    endcase
  end

  // Control FSM with pointers, count and the registered frozen flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_frozen <= 1'b0;
      r_wr_ptr <= ZERO_PTR;
      r_rd_ptr <= ZERO_PTR;
      r_count  <= ZERO_COUNT;
    end else begin
      r_count <= w_count_nxt;
      case (r_state)
        RUN: begin
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ONE_PTR;
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ONE_PTR;
          end
          if (flush) begin
            r_state  <= FLUSH;
            r_frozen <= 1'b0;
          end else if (freeze) begin
            r_state  <= FREEZE;
            r_frozen <= 1'b1;
          end else begin
            r_state  <= RUN;
            r_frozen <= 1'b0;
          end
        end
        FREEZE: begin
          if (flush) begin
            r_state  <= FLUSH;
            r_frozen <= 1'b0;
          end else if (!freeze) begin
            r_state  <= RUN;
            r_frozen <= 1'b0;
          end else begin
            r_state  <= FREEZE;
            r_frozen <= 1'b1;
          end
        end
        FLUSH: begin
          r_wr_ptr <= ZERO_PTR;
          r_rd_ptr <= ZERO_PTR;
          r_state  <= RUN;
          r_frozen <= 1'b0;
        end
        default: begin
          r_state  <= RUN;
          r_frozen <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAM_FIFO_LEVEL_EN
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(WORDS - ALMOST_FULL_MARGIN);

  logic r_almost_full;

  // Almost-full tracks the next count so it lines up with the count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_count_nxt >= AF_LEVEL);
    end
  end

  assign level       = r_count;
  assign almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl paired with a behavioural simple
// dual-port block RAM (registered read address, 1-cycle latency).
module tb_ram_fifo_ctrl;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NW = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          freeze;
  logic          flush;
  logic          frozen;
  logic          ram_we;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic [AW-1:0] ram_r_addr;
  logic [DW-1:0] ram_r_data;
`ifdef RAM_FIFO_LEVEL_EN
  logic [AW:0]   level;
  logic          almost_full;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .freeze     (freeze),
    .flush      (flush),
    .frozen     (frozen),
    .ram_we     (ram_we),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
    .ram_r_addr (ram_r_addr),
    .ram_r_data (ram_r_data)
`ifdef RAM_FIFO_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural block RAM
  logic [DW-1:0] mem [0:NW-1];
  logic [AW-1:0] r_addr_q = '0;

  always @(posedge clk) begin
    if (ram_we) mem[ram_w_addr] <= ram_w_data;
    r_addr_q <= ram_r_addr;
  end
  assign ram_r_data = mem[r_addr_q];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nin;
    int nout;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    freeze = 1'b0; flush = 1'b0;
    for (int i = 0; i < NW; i++) mem[i] = 32'h0;

    // Reset state
    step(); step();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_frozen", frozen, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_r_addr", ram_r_addr, 12'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_out_valid", out_valid, 1'b0);

    // First push, 1-cycle latency
    in_valid = 1'b1; in_data = 32'hA5A5_0001;
    #1;
    chk("push_we", ram_we, 1'b1);
    chk("push_waddr", ram_w_addr, 12'd0);
    chk("push_wdata", ram_w_data, 32'hA5A5_0001);
    step();
    in_valid = 1'b0;
    chk("lat_out_valid", out_valid, 1'b1);
    chk("lat_out_data", out_data, 32'hA5A5_0001);
    out_ready = 1'b1;
    #1;
    chk("pop_raddr_ahead", ram_r_addr, 12'd1);
    step();
    out_ready = 1'b0;
    chk("empty_out_valid", out_valid, 1'b0);

    // Fill to capacity with out_ready low (write pointer starts at 1, wraps)
    for (int i = 0; i < NW; i++) begin
      in_valid = 1'b1; in_data = 32'h1000_0000 + i;
      step();
    end
    in_data = 32'hDEAD_DEAD;
    #1;
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_no_we", ram_we, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    chk("full_head", out_data, 32'h1000_0000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("after_pop_in_ready", in_ready, 1'b1);
    chk("after_pop_head", out_data, 32'h1000_0001);
    out_ready = 1'b1;
    for (int i = 1; i < NW; i++) begin
      #1;
      chk("drain_valid", out_valid, 1'b1);
      chk("drain_data", out_data, 32'h1000_0000 + i);
      step();
    end
    out_ready = 1'b0;
    #1;
    chk("drain_empty", out_valid, 1'b0);

    // Continuous push/pop of 0..9999
    nin = 0; nout = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 10100 && nout < 10000; c++) begin
      in_valid = (nin < 10000);
      in_data = nin;
      #1;
      if (out_valid) begin
        chk("stream_data", out_data, nout);
        nout++;
      end
      if (in_valid && in_ready) nin++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_count", nout, 10000);
    #1;
    chk("stream_empty", out_valid, 1'b0);

    // Freeze with 5 words held
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'h200 + i;
      step();
    end
    in_valid = 1'b0;
    freeze = 1'b1;
    step();
    in_valid = 1'b1; in_data = 32'hBAD0_0000; out_ready = 1'b1;
    for (int c = 1; c < 10; c++) begin
      #1;
      chk("frz_frozen", frozen, 1'b1);
      chk("frz_out_valid", out_valid, 1'b0);
      chk("frz_in_ready", in_ready, 1'b0);
      chk("frz_we", ram_we, 1'b0);
      step();
    end
    freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("unfrz_frozen", frozen, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("unfrz_valid", out_valid, 1'b1);
      chk("unfrz_data", out_data, 32'h200 + i);
      step();
    end
    out_ready = 1'b0;
    #1;
    chk("unfrz_empty", out_valid, 1'b0);

    // Flush and freeze together with 7 words held
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 32'h300 + i;
      step();
    end
    in_valid = 1'b0;
    flush = 1'b1; freeze = 1'b1;
    step();
    flush = 1'b0; freeze = 1'b0;
    chk("flush_frozen", frozen, 1'b0);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b0);
    step();
    chk("postflush_out_valid", out_valid, 1'b0);
    chk("postflush_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_data = 32'h0000_BEEF;
    #1;
    chk("postflush_waddr", ram_w_addr, 12'd0);
    chk("postflush_we", ram_we, 1'b1);
    step();
    in_valid = 1'b0;
    chk("postflush_valid", out_valid, 1'b1);
    chk("postflush_data", out_data, 32'h0000_BEEF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset mid-stream with 20 words held
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 32'h400 + i;
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_raddr", ram_r_addr, 12'd0);
    step();
    rst = 1'b0;
    #1;
    chk("postrst_out_valid", out_valid, 1'b0);
    chk("postrst_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_data = 32'h0000_CAFE;
    #1;
    chk("postrst_waddr", ram_w_addr, 12'd0);
    step();
    in_valid = 1'b0;
    chk("postrst_valid", out_valid, 1'b1);
    chk("postrst_data", out_data, 32'h0000_CAFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
- REQ-001: ADDR_WIDTH, default 12, width of the RAM address ports and FIFO pointers.
- REQ-002: DATA_WIDTH, default 32, width of the data path.
- REQ-003: WORDS, default 4096, FIFO capacity, `WORDS == 2**ADDR_WIDTH` SHALL hold; any other value is unsupported.
- REQ-004: clk  in  1  single clock for all logic.
- REQ-005: rst  in  1  asynchronous, active-high reset.
- REQ-006: in_valid  in  1 / in_ready  out  1 / in_data  in  DATA_WIDTH form the producer handshake.
- REQ-007: out_valid  out  1 / out_ready  in  1 / out_data  out  DATA_WIDTH form the consumer handshake.
- REQ-008: freeze  in  1  request to halt push and pop; flush  in  1  request to discard contents.
- REQ-009: frozen  out  1  asserted while in FREEZE state.
- REQ-010: ram_we  out  1 / ram_w_addr  out  ADDR_WIDTH / ram_w_data  out  DATA_WIDTH drive the RAM write port.
- REQ-011: ram_r_addr  out  ADDR_WIDTH / ram_r_data  in  DATA_WIDTH connect to the RAM read port, which registers its address and has 1-cycle read latency.

Function
- REQ-012: The block SHALL keep wr_ptr, rd_ptr (ADDR_WIDTH, wrapping modulo WORDS) and count (ADDR_WIDTH+1).
- REQ-013: Push SHALL occur when `in_valid && in_ready`; `in_ready = (state==RUN) && (count != WORDS)`.
- REQ-014: On push, ram_we=1, ram_w_addr=wr_ptr, ram_w_data=in_data, wr_ptr increments; these are combinational from the inputs.
- REQ-015: `out_valid = (state==RUN) && (count != 0)`; out_data SHALL equal ram_r_data.
- REQ-016: Pop SHALL occur when `out_valid && out_ready`; rd_ptr increments.
- REQ-017: `ram_r_addr` SHALL be rd_ptr+1 on a pop cycle, rd_ptr otherwise, so ram_r_data always reflects the head entry one cycle later.
- REQ-018: Latency: a word pushed at edge N SHALL be visible on out_valid/out_data after edge N; this is a 1-cycle latency.
- REQ-019: Simultaneous push and pop SHALL leave count unchanged.
- REQ-020: Simultaneous push and pop SHALL be legal at count==0 only in the sense that pop is impossible; only the push takes effect.
- REQ-021: When full, in_ready=0; a push and pop in the same cycle SHALL NOT occur at full.
- REQ-022: The FSM SHALL have states RUN, FREEZE, and FLUSH.
- REQ-023: In RUN, flush SHALL take the FSM to FLUSH, and freeze SHALL take it to FREEZE.
- REQ-024: In FREEZE, pointers and count SHALL hold, in_ready=0, out_valid=0 and frozen=1; the FSM SHALL return to RUN when freeze=0 and go to FLUSH on flush.
- REQ-025: In FLUSH, wr_ptr, rd_ptr and count SHALL be cleared in one cycle and ram_we=0; the FSM SHALL then move to RUN.
- REQ-026: When both flush and freeze are asserted, flush SHALL take priority.
- REQ-027: ram_we SHALL never be asserted outside RUN.
- REQ-028: RAM contents SHALL NOT be cleared by flush.

Reset
- REQ-029: Asserting rst SHALL asynchronously set state=RUN, wr_ptr=rd_ptr=0 and count=0.
- REQ-030: During reset, outputs SHALL be in_ready=0, out_valid=0, frozen=0, ram_we=0 and ram_r_addr=0.
- REQ-031: in_ready SHALL be forced to 0 while rst is high.
- REQ-032: Reset asserted mid-transfer SHALL discard all contents; the first push after release SHALL go to address 0.

Configuration
- REQ-033: Macro RAM_FIFO_LEVEL_EN, when defined, SHALL add outputs level (ADDR_WIDTH+1, equal to count) and almost_full (1, registered, high when count >= WORDS-4).
- REQ-034: Without RAM_FIFO_LEVEL_EN, these ports and their logic SHALL be absent.

Structure
- REQ-035: The FSM state encoding (RUN=0, FREEZE=1, FLUSH=2) and the almost-full margin constant 4 SHALL live in the shared package fifo_pkg.
- REQ-036: No sub-module SHALL be instantiated; the RAM is external, and the bench SHALL pair the block with the team's simple dual-port block RAM.

Verification
- REQ-037: After reset, push 0xA5A5_0001 at cycle 1 -> out_valid=1 and out_data=0xA5A5_0001 at cycle 2.
- REQ-038: Push 4096 words with out_ready=0 -> in_ready=0 after the 4096th push; a pop then SHALL re-assert in_ready the next cycle.
- REQ-039: Continuous push/pop of the sequence 0..9999 -> output sequence identical and in order, with wrap at address 4095->0 seamless.
- REQ-040: With 5 words held, assert freeze for 10 cycles -> out_valid=0 and frozen=1; after release, the same 5 words SHALL emerge in order.
- REQ-041: With 7 words held, pulse flush and freeze together -> count=0 and out_valid=0 next cycle; the next push SHALL land at address 0.
- REQ-042: Assert rst mid-stream with count=20 -> out_valid=0 immediately; after release, count=0.
